// File: rtl/block_copy_dma.sv
// block_copy_dma: copies num_words DATA_W-bit words from src_addr to dst_addr, one read/write pair per word.
module block_copy_dma #(
    parameter int LEN_W  = 16,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
    localparam logic [31:0] STRIDE = 32'(DATA_W / 8);
    state_t           state;
    logic [31:0]      src_ptr, dst_ptr;
    logic [LEN_W-1:0] rem;
    logic             misaligned;
    assign misaligned = (src_addr[3:0] != 4'd0) || (dst_addr[3:0] != 4'd0);
    // read data arrives in the WR cycle itself, so write data is steered straight through
    assign mem_write_data = (state == WR) ? mem_read_data : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            words_done  <= '0;
            mem_address <= '0;
            mem_write   <= 1'b0;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            rem         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_ptr    <= src_addr;
                    dst_ptr    <= dst_addr;
                    rem        <= num_words;
                    words_done <= '0;
                    if (num_words == '0 || misaligned) begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= (num_words != '0) && misaligned;
                    end else begin
                        state       <= RD;
                        busy        <= 1'b1;
                        mem_address <= src_addr;
                    end
                end
                RD: if (abort) begin
                    state       <= FIN;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    mem_address <= '0;
                end else begin
                    state       <= WR;
                    mem_write   <= 1'b1;
                    mem_address <= dst_ptr;
                end
                WR: begin
                    src_ptr    <= src_ptr + STRIDE;
                    dst_ptr    <= dst_ptr + STRIDE;
                    words_done <= words_done + LEN_W'(1);
                    rem        <= rem - LEN_W'(1);
                    mem_write  <= 1'b0;
                    if (rem == LEN_W'(1) || abort) begin
                        state       <= FIN;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        mem_address <= '0;
                    end else begin
                        state       <= RD;
                        mem_address <= src_ptr + STRIDE;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_copy_dma.sv
// tb_block_copy_dma: random and directed copy jobs against a word-array reference model with a write/done scoreboard.
module tb_block_copy_dma;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [31:0]  src_addr = '0, dst_addr = '0;
    logic [15:0]  num_words = '0;
    logic         busy, done, err, mem_write;
    logic [15:0]  words_done;
    logic [31:0]  mem_address;
    logic [127:0] mem_write_data, mem_read_data;

    block_copy_dma #(.LEN_W(16), .DATA_W(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .num_words(num_words), .abort(abort), .busy(busy), .done(done), .err(err),
        .words_done(words_done), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [127:0] d; int c; } wr_t;
    typedef struct { logic e; logic [15:0] n; int c; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    wr_t wm;
    dn_t dm;
    logic [127:0] mem [256];
    logic [127:0] ref_mem [256];
    int cyc = 0, checks = 0, failures = 0, job_s = 0, job_end = 0;

    // memory with registered read: read data reflects contents before a same-edge write
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[11:4]] <= mem_write_data;
        mem_read_data <= mem[mem_address[11:4]];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_words_done"}, words_done, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_wdata"}, mem_write_data, 0);
        chk({tag, "_write"}, mem_write, 0);
    endtask

    always @(negedge clk) if (rst_n) begin
        if (mem_write) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                wm = wq.pop_front();
                chk("wr_addr", mem_address, wm.a);
                chk("wr_data", mem_write_data, wm.d);
                chk("wr_cycle", cyc, wm.c);
            end
        end
        if (done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                dm = dq.pop_front();
                chk("done_err", err, dm.e);
                chk("done_words", words_done, dm.n);
                chk("done_cycle", cyc, dm.c);
            end
        end else chk("err_without_done", err, 0);
        chk("busy", busy, (cyc > job_s) && (cyc < job_end));
        if (!busy) begin
            chk("idle_addr", mem_address, 0);
            chk("idle_wdata", mem_write_data, 0);
            chk("idle_write", mem_write, 0);
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode: 0 full copy, 1 abort in WR of word j, 2 abort in RD of word j, 3 reset in WR of word 1
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n, input int mode, input int j);
        int n_eff, done_off, ab_c;
        logic e;
        logic [31:0] a, b;
        logic [127:0] v;
        ab_c = -1;
        e = 1'b0;
        if (n == 0) begin n_eff = 0; done_off = 1; end
        else if (s[3:0] != 0 || d[3:0] != 0) begin n_eff = 0; e = 1'b1; done_off = 1; end
        else if (mode == 1) begin n_eff = j + 1; done_off = 2 * j + 3; ab_c = 2 * j + 2; end
        else if (mode == 2) begin n_eff = j; done_off = 2 * j + 2; ab_c = 2 * j + 1; end
        else if (mode == 3) begin n_eff = 1; done_off = 4; end
        else begin n_eff = n; done_off = 2 * n + 1; end
        @(posedge clk);
        #1;
        for (int k = 0; k < n_eff; k++) begin
            a = s + 32'(16 * k);
            b = d + 32'(16 * k);
            v = ref_mem[a[11:4]];
            ref_mem[b[11:4]] = v;
            wq.push_back('{b, v, cyc + 2 * k + 2});
        end
        if (mode != 3) dq.push_back('{e, 16'(n_eff), cyc + done_off});
        job_s = cyc;
        job_end = cyc + done_off;
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        num_words = 16'(n);
        for (int i = 1; i <= done_off + 1; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = (i == ab_c);
            if (i == 3 && i < done_off - 1 && mode != 3) begin
                start = 1'b1;
                src_addr = $urandom;
                dst_addr = $urandom;
                num_words = 16'($urandom);
            end
            if (mode == 3 && i == 4) begin
                #1 rst_n = 1'b0;
                #1 chk_zero_outputs("async_reset");
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, d;
        int n, mode, j, mism;
        for (int i = 0; i < 256; i++) begin
            mem[i] = rnd128();
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[8'h10 + i] = 128'hA0A0_0000_0000_0000_0000_0000_0000_0000 + 128'(i);
            ref_mem[8'h10 + i] = mem[8'h10 + i];
        end
        #3 chk_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_job(32'h100, 32'h400, 4, 0, 0);
        for (int i = 0; i < 4; i++)
            chk("t1_copy", mem[8'h40 + i], 128'hA0A0_0000_0000_0000_0000_0000_0000_0000 + 128'(i));
        run_job(32'h200, 32'h600, 0, 0, 0);
        run_job(32'h104, 32'h400, 3, 0, 0);
        run_job(32'h100, 32'h408, 3, 0, 0);
        run_job(32'h300, 32'h800, 8, 1, 2);
        run_job(32'h300, 32'h900, 8, 2, 3);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        mem[8'h10] = rnd128();
        ref_mem[8'h10] = mem[8'h10];
        run_job(32'h100, 32'h110, 3, 0, 0);
        for (int i = 1; i < 4; i++) chk("t5_forward", mem[8'h10 + i], mem[8'h10]);
        run_job(32'hA00, 32'hB00, 4, 3, 0);
        run_job(32'hA00, 32'hC00, 4, 0, 0);

        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            s = 32'($urandom_range(0, 255 - n)) << 4;
            d = 32'($urandom_range(0, 255 - n)) << 4;
            if ($urandom_range(0, 7) == 0) s[3:0] = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) d[3:0] = 4'($urandom_range(1, 15));
            mode = $urandom_range(0, 2);
            j = (n > 0) ? $urandom_range(0, n - 1) : 0;
            run_job(s, d, n, mode, j);
        end

        repeat (3) @(posedge clk);
        #1;
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_final_mismatches", mism, 0);
        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
